// File: rtl/load_store_unit_if.sv
// ----------------------------------------------------------------------------
// load_store_unit_if
//   Bundles the three buses of the load/store unit:
//   - request   (execute stage -> LSU)
//   - response  (LSU -> writeback)
//   - word port (LSU <-> data memory)
//
//   The slave modport is the LSU side. The master modport is the combined
//   environment side: execute stage, writeback stage and data memory.
//
// Signals
//   req_valid / req_ready     request handshake
//   req_write                 1 = store, 0 = load
//   req_f3                    RV32I funct3 width/sign code
//   req_addr / req_wdata      byte address, store data
//   resp_valid / resp_ready   response handshake
//   resp_rdata / resp_err     extended load data, error flag
//   mem_re / mem_we           word read / write strobes
//   mem_idx                   word index
//   mem_wdata / mem_rdata     write word, read word (read is valid the
//                             cycle after mem_re)
// ----------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 6
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_f3;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [ADDR_W-1:0] resp_rdata;
    logic              resp_err;

    logic              mem_re;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [ADDR_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_f3, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_re, mem_we, mem_idx, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_f3, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_re, mem_we, mem_idx, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//   Byte-addressed load/store front end for a word-organised data memory.
//   The unit takes one request at a time and checks funct3, range and
//   alignment at accept time. It then turns the request into word accesses:
//   - loads:  read the word, then extract and sign/zero-extend the lane
//   - SW:     single word write
//   - SB/SH:  read-modify-write of the containing word
//   Each request produces exactly one response, which is held until it is
//   taken.
//
// Ports
//   clk     in  system clock, rising edge
//   rst_n   in  asynchronous active-low reset
//   bus     load_store_unit_if.slave -- request, response and memory buses
//
// Parameters
//   ADDR_W  byte-address / data width
//   IDX_W   word-index width (2**IDX_W words)
// ----------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    load_store_unit_if.slave       bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_RESP
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t            r_state;
    state_t            w_next;

    logic              r_write;
    logic [2:0]        r_f3;
    logic [1:0]        r_lane;
    logic [IDX_W-1:0]  r_idx;
    // Holds the raw store data from accept until CAP, then the merged word.
    logic [ADDR_W-1:0] r_mwdata;
    logic [ADDR_W-1:0] r_rdata;
    logic              r_err;

    logic              w_accept;
    logic              w_f3_bad;
    logic              w_range_bad;
    logic              w_misalign;
    logic              w_chk_err;

    // ------------------------------------------------------------------------
    // Load extract: pick the byte/half lane and extend it to full width.
    // ------------------------------------------------------------------------
    function automatic logic [ADDR_W-1:0] f_extract(
        input logic [ADDR_W-1:0] word,
        input logic [2:0]        f3,
        input logic [1:0]        lane
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (f3)
            F3_B:    f_extract = {{(ADDR_W-8){b[7]}}, b};
            F3_BU:   f_extract = {{(ADDR_W-8){1'b0}}, b};
            F3_H:    f_extract = {{(ADDR_W-16){h[15]}}, h};
            F3_HU:   f_extract = {{(ADDR_W-16){1'b0}}, h};
            default: f_extract = word;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Store merge: overwrite one byte/half lane of the old word.
    // ------------------------------------------------------------------------
    function automatic logic [ADDR_W-1:0] f_merge(
        input logic [ADDR_W-1:0] old_word,
        input logic [ADDR_W-1:0] wdata,
        input logic [2:0]        f3,
        input logic [1:0]        lane
    );
        logic [ADDR_W-1:0] w;
        w = old_word;
        case (f3)
            F3_B:    w[{lane, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    w[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: w = wdata;
        endcase
        return w;
    endfunction

    // ------------------------------------------------------------------------
    // Accept-time checks. Any one of them sends the request straight to RESP
    // with the error flag set, so no memory strobe is ever issued for it.
    // ------------------------------------------------------------------------
    always_comb begin
        w_f3_bad    = 1'b0;
        w_range_bad = 1'b0;
        w_misalign  = 1'b0;

        if (bus.req_write) begin
            w_f3_bad = !(bus.req_f3 == F3_B || bus.req_f3 == F3_H ||
                         bus.req_f3 == F3_W);
        end else begin
            w_f3_bad = (bus.req_f3 == 3'b011) || (bus.req_f3 == 3'b110) ||
                       (bus.req_f3 == 3'b111);
        end

        w_range_bad = |bus.req_addr[ADDR_W-1:IDX_W+2];

        // f3[1:0] distinguishes H/HU (01) from W (10) once f3 is known legal.
        w_misalign = ((bus.req_f3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_f3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    end

    assign w_chk_err = w_f3_bad || w_range_bad || w_misalign;
    assign w_accept  = (r_state == S_IDLE) && bus.req_valid;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (w_chk_err) begin
                        w_next = S_RESP;
                    end else if (bus.req_write && (bus.req_f3 == F3_W)) begin
                        w_next = S_WR;
                    end else begin
                        w_next = S_RD;
                    end
                end
            end
            S_RD:    w_next = S_CAP;
            S_CAP:   w_next = r_write ? S_WR : S_RESP;
            S_WR:    w_next = S_RESP;
            S_RESP:  if (bus.resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Request latch and data capture. Reset clears everything so that an
    // abandoned access leaves no stale index or write word on the memory port.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write  <= 1'b0;
            r_f3     <= 3'b000;
            r_lane   <= 2'b00;
            r_idx    <= '0;
            r_mwdata <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_write  <= bus.req_write;
            r_f3     <= bus.req_f3;
            r_lane   <= bus.req_addr[1:0];
            r_idx    <= bus.req_addr[IDX_W+1:2];
            r_mwdata <= bus.req_wdata;
            r_rdata  <= '0;
            r_err    <= w_chk_err;
        end else if (r_state == S_CAP) begin
            if (r_write) begin
                r_mwdata <= f_merge(bus.mem_rdata, r_mwdata, r_f3, r_lane);
            end else begin
                r_rdata  <= f_extract(bus.mem_rdata, r_f3, r_lane);
            end
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
    assign bus.mem_re     = (r_state == S_RD);
    assign bus.mem_we     = (r_state == S_WR);
    assign bus.mem_idx    = r_idx;
    assign bus.mem_wdata  = r_mwdata;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic clk;
    logic rst_n;

    load_store_unit_if #(.ADDR_W(32), .IDX_W(6)) ifc ();

    load_store_unit #(.ADDR_W(32), .IDX_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_we  = 0;

    // Simple word memory with a bench-side preload port.
    logic [31:0] mem [64];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (ifc.mem_re) ifc.mem_rdata <= mem[ifc.mem_idx];
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (ifc.mem_we) begin
            mem[ifc.mem_idx] <= ifc.mem_wdata;
            n_we <= n_we + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        pl_en   = 1'b1;
        pl_idx  = idx;
        pl_data = data;
        tick();
        pl_en   = 1'b0;
    endtask

    // Presents a request for one cycle; returns at the negedge of T1.
    task automatic send(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
        chk({tag, ".req_ready"}, {31'd0, ifc.req_ready}, 32'd1);
        ifc.req_valid = 1'b1;
        ifc.req_write = wr;
        ifc.req_f3    = f3;
        ifc.req_addr  = addr;
        ifc.req_wdata = wdata;
        tick();
        ifc.req_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] exp);
        send(tag, 1'b0, f3, addr, 32'h0);
        chk({tag, ".T1.mem_re"},  {31'd0, ifc.mem_re}, 32'd1);
        chk({tag, ".T1.idx"},     {26'd0, ifc.mem_idx}, {26'd0, addr[7:2]});
        tick();
        chk({tag, ".T2.vld"},     {31'd0, ifc.resp_valid}, 32'd0);
        tick();
        chk({tag, ".T3.vld"},     {31'd0, ifc.resp_valid}, 32'd1);
        chk({tag, ".T3.rdata"},   ifc.resp_rdata, exp);
        chk({tag, ".T3.err"},     {31'd0, ifc.resp_err}, 32'd0);
        tick();
    endtask

    task automatic do_err(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr);
        send(tag, wr, f3, addr, 32'hFFFF_FFFF);
        chk({tag, ".T1.vld"},   {31'd0, ifc.resp_valid}, 32'd1);
        chk({tag, ".T1.err"},   {31'd0, ifc.resp_err}, 32'd1);
        chk({tag, ".T1.rdata"}, ifc.resp_rdata, 32'h0);
        chk({tag, ".T1.strb"},  {30'd0, ifc.mem_re, ifc.mem_we}, 32'd0);
        tick();
        chk({tag, ".T2.strb"},  {30'd0, ifc.mem_re, ifc.mem_we}, 32'd0);
    endtask

    int we_snap;

    initial begin
        rst_n          = 1'b0;
        ifc.req_valid  = 1'b0;
        ifc.req_write  = 1'b0;
        ifc.req_f3     = 3'b000;
        ifc.req_addr   = 32'h0;
        ifc.req_wdata  = 32'h0;
        ifc.resp_ready = 1'b1;
        pl_en          = 1'b0;
        pl_idx         = 6'd0;
        pl_data        = 32'h0;

        // Reset state
        tick();
        chk("rst.req_ready",  {31'd0, ifc.req_ready}, 32'd1);
        chk("rst.resp_valid", {31'd0, ifc.resp_valid}, 32'd0);
        chk("rst.strobes",    {30'd0, ifc.mem_re, ifc.mem_we}, 32'd0);
        chk("rst.rdata",      ifc.resp_rdata, 32'h0);
        chk("rst.idx",        {26'd0, ifc.mem_idx}, 32'd0);
        chk("rst.wdata",      ifc.mem_wdata, 32'h0);
        chk("rst.err",        {31'd0, ifc.resp_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // SW 0xDEADBEEF @0x10
        send("sw", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        chk("sw.T1.we",    {31'd0, ifc.mem_we}, 32'd1);
        chk("sw.T1.re",    {31'd0, ifc.mem_re}, 32'd0);
        chk("sw.T1.idx",   {26'd0, ifc.mem_idx}, 32'd4);
        chk("sw.T1.wdata", ifc.mem_wdata, 32'hDEAD_BEEF);
        chk("sw.T1.ready", {31'd0, ifc.req_ready}, 32'd0);
        tick();
        chk("sw.T2.vld",   {31'd0, ifc.resp_valid}, 32'd1);
        chk("sw.T2.err",   {31'd0, ifc.resp_err}, 32'd0);
        chk("sw.T2.rdata", ifc.resp_rdata, 32'h0);
        chk("sw.T2.we",    {31'd0, ifc.mem_we}, 32'd0);
        chk("sw.mem4",     mem[4], 32'hDEAD_BEEF);
        tick();

        // Loads from word 0x80FF017F
        preload(6'd4, 32'h80FF_017F);
        do_load("lb13",  3'b000, 32'h13, 32'hFFFF_FF80);
        do_load("lbu13", 3'b100, 32'h13, 32'h0000_0080);
        do_load("lh12",  3'b001, 32'h12, 32'hFFFF_80FF);
        do_load("lhu10", 3'b101, 32'h10, 32'h0000_017F);
        do_load("lb12",  3'b000, 32'h12, 32'hFFFF_FFFF);
        do_load("lb10",  3'b000, 32'h10, 32'h0000_007F);
        do_load("lw10",  3'b010, 32'h10, 32'h80FF_017F);

        // SB 0xAA @0x11 over 0x11223344
        preload(6'd4, 32'h1122_3344);
        send("sb", 1'b1, 3'b000, 32'h11, 32'h0000_00AA);
        chk("sb.T1.strb", {30'd0, ifc.mem_re, ifc.mem_we}, 32'd2);
        tick();
        chk("sb.T2.strb", {30'd0, ifc.mem_re, ifc.mem_we}, 32'd0);
        tick();
        chk("sb.T3.strb",  {30'd0, ifc.mem_re, ifc.mem_we}, 32'd1);
        chk("sb.T3.idx",   {26'd0, ifc.mem_idx}, 32'd4);
        chk("sb.T3.wdata", ifc.mem_wdata, 32'h1122_AA44);
        tick();
        chk("sb.T4.vld",   {31'd0, ifc.resp_valid}, 32'd1);
        chk("sb.T4.rdata", ifc.resp_rdata, 32'h0);
        chk("sb.mem4",     mem[4], 32'h1122_AA44);
        tick();

        // SH 0xBEEF @0x12 over 0x1122AA44
        send("sh", 1'b1, 3'b001, 32'h12, 32'h1234_BEEF);
        tick();
        tick();
        chk("sh.T3.we",    {31'd0, ifc.mem_we}, 32'd1);
        chk("sh.T3.wdata", ifc.mem_wdata, 32'hBEEF_AA44);
        tick();
        chk("sh.T4.vld",   {31'd0, ifc.resp_valid}, 32'd1);
        tick();
        chk("sh.mem4",     mem[4], 32'hBEEF_AA44);

        // Error cases
        we_snap = n_we;
        do_err("e_sh11",   1'b1, 3'b001, 32'h11);
        do_err("e_lw102",  1'b0, 3'b010, 32'h102);
        do_err("e_f3_011", 1'b0, 3'b011, 32'h10);
        do_err("e_lb100",  1'b0, 3'b000, 32'h100);
        do_err("e_st100",  1'b1, 3'b100, 32'h10);
        do_err("e_lw101",  1'b0, 3'b010, 32'h11);
        chk("err.no_we", n_we, we_snap);
        chk("err.mem4",  mem[4], 32'hBEEF_AA44);

        // Back-pressure with a second request waiting
        ifc.resp_ready = 1'b0;
        send("bp", 1'b0, 3'b010, 32'h10, 32'h0);
        tick();
        tick();
        chk("bp.T3.vld", {31'd0, ifc.resp_valid}, 32'd1);
        ifc.req_valid = 1'b1;
        ifc.req_write = 1'b0;
        ifc.req_f3    = 3'b101;
        ifc.req_addr  = 32'h12;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp.stall.vld",   {31'd0, ifc.resp_valid}, 32'd1);
            chk("bp.stall.rdata", ifc.resp_rdata, 32'hBEEF_AA44);
            chk("bp.stall.ready", {31'd0, ifc.req_ready}, 32'd0);
            chk("bp.stall.strb",  {30'd0, ifc.mem_re, ifc.mem_we}, 32'd0);
        end
        ifc.resp_ready = 1'b1;
        chk("bp.take.ready", {31'd0, ifc.req_ready}, 32'd0);
        tick();
        chk("bp.idle.ready", {31'd0, ifc.req_ready}, 32'd1);
        chk("bp.idle.vld",   {31'd0, ifc.resp_valid}, 32'd0);
        tick();
        ifc.req_valid = 1'b0;
        chk("bp2.T1.re",    {31'd0, ifc.mem_re}, 32'd1);
        tick();
        tick();
        chk("bp2.T3.vld",   {31'd0, ifc.resp_valid}, 32'd1);
        chk("bp2.T3.rdata", ifc.resp_rdata, 32'h0000_BEEF);
        tick();

        // Reset during CAP of an SB
        preload(6'd5, 32'h5566_7788);
        we_snap = n_we;
        send("rsb", 1'b1, 3'b000, 32'h14, 32'h0000_0099);
        chk("rsb.T1.re", {31'd0, ifc.mem_re}, 32'd1);
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("rsb.rst.ready", {31'd0, ifc.req_ready}, 32'd1);
        chk("rsb.rst.vld",   {31'd0, ifc.resp_valid}, 32'd0);
        chk("rsb.rst.strb",  {30'd0, ifc.mem_re, ifc.mem_we}, 32'd0);
        chk("rsb.rst.idx",   {26'd0, ifc.mem_idx}, 32'd0);
        chk("rsb.rst.wdata", ifc.mem_wdata, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("rsb.no_we", n_we, we_snap);
        chk("rsb.mem5",  mem[5], 32'h5566_7788);
        do_load("rsb.lw14", 3'b010, 32'h14, 32'h5566_7788);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
